// File: rtl/pspin_her_tracker.sv
// rtl/pspin_her_tracker.sv - in-flight packet table turning DMA write completions into HERs and handler completions into slot-free feedback
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_done_*                    DMA write completion in (addr, len, tag)
//   her_*                        handler execution request out (addr, size, msgid)
//   cpl_*                        handler completion in (buffer addr)
//   feedback_*                   slot-free feedback out (addr, size, msgid)
//   inflight_count_o             number of valid table entries
//   unmatched_cpl_o              saturating count of completions that hit no entry

module pspin_her_tracker #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int TAG_WIDTH   = 32,
  parameter int MSGID_WIDTH = 10,
  parameter int DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       wr_done_valid_i,
  output logic                       wr_done_ready_o,
  input  logic [ADDR_WIDTH-1:0]      wr_done_addr_i,
  input  logic [LEN_WIDTH-1:0]       wr_done_len_i,
  input  logic [TAG_WIDTH-1:0]       wr_done_tag_i,

  output logic                       her_valid_o,
  input  logic                       her_ready_i,
  output logic [ADDR_WIDTH-1:0]      her_addr_o,
  output logic [LEN_WIDTH-1:0]       her_size_o,
  output logic [MSGID_WIDTH-1:0]     her_msgid_o,

  input  logic                       cpl_valid_i,
  output logic                       cpl_ready_o,
  input  logic [ADDR_WIDTH-1:0]      cpl_addr_i,

  output logic                       feedback_valid_o,
  input  logic                       feedback_ready_i,
  output logic [ADDR_WIDTH-1:0]      feedback_her_addr_o,
  output logic [LEN_WIDTH-1:0]       feedback_her_size_o,
  output logic [MSGID_WIDTH-1:0]     feedback_msgid_o,

  output logic [$clog2(DEPTH):0]     inflight_count_o,
  output logic [31:0]                unmatched_cpl_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]       ent_valid;
  logic [ADDR_WIDTH-1:0]  ent_addr  [DEPTH];
  logic [LEN_WIDTH-1:0]   ent_len   [DEPTH];
  logic [MSGID_WIDTH-1:0] ent_msgid [DEPTH];

  logic                   her_valid_q;
  logic [ADDR_WIDTH-1:0]  her_addr_q;
  logic [LEN_WIDTH-1:0]   her_size_q;
  logic [MSGID_WIDTH-1:0] her_msgid_q;

  logic                   fb_valid_q;
  logic [ADDR_WIDTH-1:0]  fb_addr_q;
  logic [LEN_WIDTH-1:0]   fb_size_q;
  logic [MSGID_WIDTH-1:0] fb_msgid_q;

  logic [CNT_W-1:0]       inflight_q;
  logic [31:0]            unmatched_q;

  logic                   any_free;
  logic [IDX_W-1:0]       free_idx;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   alloc;
  logic                   cpl_fire;
  logic                   hit_fire;

  // Only the low tag bits carry the message id; the rest is intentionally ignored.
  logic                   unused_tag_bits;
  assign unused_tag_bits = ^wr_done_tag_i;

  // Lowest-index free slot. Scanning downward lets the last assignment win.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index match against registered entries only, so an entry written
  // this cycle cannot be hit by a completion arriving in the same cycle.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_addr[i] == cpl_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Free slots come from registered valid bits, so a slot released this
  // cycle is only offered again on the next one.
  assign wr_done_ready_o = !rst && any_free && (!her_valid_q || her_ready_i);
  assign cpl_ready_o     = !rst && (!fb_valid_q || feedback_ready_i);

  assign alloc    = wr_done_valid_i && wr_done_ready_o;
  assign cpl_fire = cpl_valid_i && cpl_ready_o;
  assign hit_fire = cpl_fire && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i]  <= '0;
        ent_len[i]   <= '0;
        ent_msgid[i] <= '0;
      end
      her_valid_q <= 1'b0;
      her_addr_q  <= '0;
      her_size_q  <= '0;
      her_msgid_q <= '0;
      fb_valid_q  <= 1'b0;
      fb_addr_q   <= '0;
      fb_size_q   <= '0;
      fb_msgid_q  <= '0;
      inflight_q  <= '0;
      unmatched_q <= '0;
    end else begin
      // alloc and hit never target the same slot: alloc picks an invalid
      // entry, hit only considers valid ones.
      if (alloc) begin
        ent_valid[free_idx] <= 1'b1;
        ent_addr[free_idx]  <= wr_done_addr_i;
        ent_len[free_idx]   <= wr_done_len_i;
        ent_msgid[free_idx] <= wr_done_tag_i[MSGID_WIDTH-1:0];
      end
      if (hit_fire) begin
        ent_valid[hit_idx] <= 1'b0;
      end

      if (alloc) begin
        her_valid_q <= 1'b1;
        her_addr_q  <= wr_done_addr_i;
        her_size_q  <= wr_done_len_i;
        her_msgid_q <= wr_done_tag_i[MSGID_WIDTH-1:0];
      end else if (her_valid_q && her_ready_i) begin
        her_valid_q <= 1'b0;
      end

      if (hit_fire) begin
        fb_valid_q <= 1'b1;
        fb_addr_q  <= ent_addr[hit_idx];
        fb_size_q  <= ent_len[hit_idx];
        fb_msgid_q <= ent_msgid[hit_idx];
      end else if (fb_valid_q && feedback_ready_i) begin
        fb_valid_q <= 1'b0;
      end

      case ({alloc, hit_fire})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase

      if (cpl_fire && !hit && (unmatched_q != 32'hFFFF_FFFF)) begin
        unmatched_q <= unmatched_q + 32'd1;
      end
    end
  end

  assign her_valid_o         = her_valid_q;
  assign her_addr_o          = her_addr_q;
  assign her_size_o          = her_size_q;
  assign her_msgid_o         = her_msgid_q;
  assign feedback_valid_o    = fb_valid_q;
  assign feedback_her_addr_o = fb_addr_q;
  assign feedback_her_size_o = fb_size_q;
  assign feedback_msgid_o    = fb_msgid_q;
  assign inflight_count_o    = inflight_q;
  assign unmatched_cpl_o     = unmatched_q;

endmodule

// File: tb/tb_pspin_her_tracker.sv
// tb/tb_pspin_her_tracker.sv - self-checking bench for pspin_her_tracker

module tb_pspin_her_tracker;

  localparam int AW = 32;
  localparam int LW = 20;
  localparam int TW = 32;
  localparam int MW = 10;
  localparam int D  = 16;
  localparam logic [31:0] BASE = 32'h1c10_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_done_valid_i = 1'b0;
  logic          wr_done_ready_o;
  logic [AW-1:0] wr_done_addr_i = '0;
  logic [LW-1:0] wr_done_len_i = '0;
  logic [TW-1:0] wr_done_tag_i = '0;
  logic          her_valid_o;
  logic          her_ready_i = 1'b1;
  logic [AW-1:0] her_addr_o;
  logic [LW-1:0] her_size_o;
  logic [MW-1:0] her_msgid_o;
  logic          cpl_valid_i = 1'b0;
  logic          cpl_ready_o;
  logic [AW-1:0] cpl_addr_i = '0;
  logic          feedback_valid_o;
  logic          feedback_ready_i = 1'b1;
  logic [AW-1:0] feedback_her_addr_o;
  logic [LW-1:0] feedback_her_size_o;
  logic [MW-1:0] feedback_msgid_o;
  logic [$clog2(D):0] inflight_count_o;
  logic [31:0]   unmatched_cpl_o;

  always #5 clk = ~clk;

  pspin_her_tracker #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .MSGID_WIDTH(MW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_done_valid_i(wr_done_valid_i), .wr_done_ready_o(wr_done_ready_o),
    .wr_done_addr_i(wr_done_addr_i), .wr_done_len_i(wr_done_len_i), .wr_done_tag_i(wr_done_tag_i),
    .her_valid_o(her_valid_o), .her_ready_i(her_ready_i), .her_addr_o(her_addr_o),
    .her_size_o(her_size_o), .her_msgid_o(her_msgid_o),
    .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_addr_i(cpl_addr_i),
    .feedback_valid_o(feedback_valid_o), .feedback_ready_i(feedback_ready_i),
    .feedback_her_addr_o(feedback_her_addr_o), .feedback_her_size_o(feedback_her_size_o),
    .feedback_msgid_o(feedback_msgid_o),
    .inflight_count_o(inflight_count_o), .unmatched_cpl_o(unmatched_cpl_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // ---------------- reference model ----------------
  // Slots: lowest free slot is taken, lowest matching slot is released.
  bit          m_v   [D];
  logic [31:0] m_a   [D];
  logic [31:0] m_l   [D];
  logic [31:0] m_id  [D];
  bit          m_her_v, m_fb_v, m_zero, started;
  logic [31:0] m_her_a, m_her_l, m_her_id, m_fb_a, m_fb_l, m_fb_id;
  longint      m_unm;

  always @(negedge clk) begin : model
    int  used, fslot, hslot;
    bit  exp_wr, exp_cpl, do_alloc, do_cpl;
    if (rst) started = 1'b1;
    if (started) begin
      used = 0;
      for (int i = 0; i < D; i++) used += m_v[i] ? 1 : 0;
      exp_wr  = !rst && (used < D) && (!m_her_v || her_ready_i);
      exp_cpl = !rst && (!m_fb_v || feedback_ready_i);

      chk("wr_ready", wr_done_ready_o, exp_wr);
      chk("cpl_ready", cpl_ready_o, exp_cpl);
      chk("her_valid", her_valid_o, m_her_v);
      chk("fb_valid", feedback_valid_o, m_fb_v);
      chk("inflight", inflight_count_o, used);
      chk("unmatched", unmatched_cpl_o, m_unm);
      if (m_her_v || m_zero) begin
        chk("her_addr", her_addr_o, m_her_a);
        chk("her_size", her_size_o, m_her_l);
        chk("her_msgid", her_msgid_o, m_her_id);
      end
      if (m_fb_v || m_zero) begin
        chk("fb_addr", feedback_her_addr_o, m_fb_a);
        chk("fb_size", feedback_her_size_o, m_fb_l);
        chk("fb_msgid", feedback_msgid_o, m_fb_id);
      end

      if (rst) begin
        for (int i = 0; i < D; i++) m_v[i] = 1'b0;
        m_her_v = 0; m_fb_v = 0; m_zero = 1; m_unm = 0;
        m_her_a = 0; m_her_l = 0; m_her_id = 0;
        m_fb_a = 0;  m_fb_l = 0;  m_fb_id = 0;
      end else begin
        m_zero   = 0;
        do_alloc = wr_done_valid_i && exp_wr;
        do_cpl   = cpl_valid_i && exp_cpl;
        fslot = -1;
        hslot = -1;
        for (int i = 0; i < D; i++) begin
          if (fslot < 0 && !m_v[i]) fslot = i;
          if (hslot < 0 && m_v[i] && m_a[i] == cpl_addr_i) hslot = i;
        end
        if (do_cpl && hslot < 0 && m_unm < 64'hFFFF_FFFF) m_unm++;
        if (do_cpl && hslot >= 0) begin
          m_fb_v = 1; m_fb_a = m_a[hslot]; m_fb_l = m_l[hslot]; m_fb_id = m_id[hslot];
          m_v[hslot] = 0;
        end else if (m_fb_v && feedback_ready_i) m_fb_v = 0;
        if (do_alloc) begin
          m_her_v = 1; m_her_a = wr_done_addr_i; m_her_l = wr_done_len_i;
          m_her_id = wr_done_tag_i % (1 << MW);
          m_v[fslot] = 1; m_a[fslot] = m_her_a; m_l[fslot] = m_her_l; m_id[fslot] = m_her_id;
        end else if (m_her_v && her_ready_i) m_her_v = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [19:0] l, input logic [31:0] t);
    wr_done_valid_i = 1; wr_done_addr_i = a; wr_done_len_i = l; wr_done_tag_i = t;
    step();
    wr_done_valid_i = 0;
  endtask

  task automatic cpl_fb(input string nm, input logic [31:0] a, input logic [31:0] l, input logic [31:0] id);
    cpl_valid_i = 1; cpl_addr_i = a;
    step();
    cpl_valid_i = 0;
    #1;
    chk({nm, "_v"}, feedback_valid_o, 1);
    chk({nm, "_a"}, feedback_her_addr_o, a);
    chk({nm, "_l"}, feedback_her_size_o, l);
    chk({nm, "_id"}, feedback_msgid_o, id);
  endtask

  logic [31:0] pool [8];

  initial begin
    repeat (3) step();
    chk("rst_wr_ready", wr_done_ready_o, 0);
    chk("rst_cpl_ready", cpl_ready_o, 0);
    chk("rst_inflight", inflight_count_o, 0);
    rst = 0;

    // single packet round trip
    wr_done_valid_i = 1; wr_done_addr_i = BASE; wr_done_len_i = 1500; wr_done_tag_i = 32'h005;
    #1 chk("first_wr_ready", wr_done_ready_o, 1);
    step();
    wr_done_valid_i = 0;
    chk("her1_v", her_valid_o, 1);
    chk("her1_a", her_addr_o, 32'h1c10_0000);
    chk("her1_l", her_size_o, 1500);
    chk("her1_id", her_msgid_o, 5);
    chk("her1_cnt", inflight_count_o, 1);
    cpl_fb("fb1", BASE, 1500, 5);
    chk("fb1_cnt", inflight_count_o, 0);

    // completion on an empty table
    cpl_valid_i = 1; cpl_addr_i = 32'hdead_beef;
    step();
    cpl_valid_i = 0;
    #1;
    chk("miss_fb_v", feedback_valid_o, 0);
    chk("miss_cnt", unmatched_cpl_o, 1);
    chk("miss_cpl_ready", cpl_ready_o, 1);

    // fill the table, free entry 7, reuse it
    for (int i = 0; i < D; i++) alloc(BASE + i * 32'h600, 20'(100 + i), i);
    #1;
    chk("full_wr_ready", wr_done_ready_o, 0);
    chk("full_cnt", inflight_count_o, 16);
    cpl_valid_i = 1; cpl_addr_i = BASE + 7 * 32'h600;
    #1 chk("freeing_wr_ready", wr_done_ready_o, 0);
    step();
    cpl_valid_i = 0;
    #1;
    chk("freed_wr_ready", wr_done_ready_o, 1);
    chk("freed_fb_l", feedback_her_size_o, 107);
    alloc(BASE + 10 * 32'h600, 77, 32'h3A);
    #1 chk("refull_wr_ready", wr_done_ready_o, 0);
    // duplicate address now lives in slot 7 and slot 10; slot 7 wins first
    cpl_fb("dup7", BASE + 10 * 32'h600, 77, 32'h3A);
    cpl_fb("dup10", BASE + 10 * 32'h600, 110, 10);

    // reset with work in flight
    wr_done_valid_i = 1; wr_done_addr_i = 32'h55; rst = 1;
    step();
    wr_done_valid_i = 0;
    chk("mid_rst_her_v", her_valid_o, 0);
    chk("mid_rst_fb_v", feedback_valid_o, 0);
    chk("mid_rst_cnt", inflight_count_o, 0);
    chk("mid_rst_unm", unmatched_cpl_o, 0);
    chk("mid_rst_fb_a", feedback_her_addr_o, 0);
    rst = 0;
    step();

    // back-pressured feedback with a second hit waiting
    feedback_ready_i = 0;
    alloc(32'h1c20_0000, 11, 32'h101);
    alloc(32'h1c20_0600, 22, 32'h7FF);
    cpl_valid_i = 1; cpl_addr_i = 32'h1c20_0000;
    step();
    cpl_addr_i = 32'h1c20_0600;
    #1;
    chk("bp_cpl_ready0", cpl_ready_o, 0);
    repeat (2) begin
      step();
      chk("bp_hold_a", feedback_her_addr_o, 32'h1c20_0000);
      chk("bp_hold_l", feedback_her_size_o, 11);
      chk("bp_hold_id", feedback_msgid_o, 32'h101);
      chk("bp_hold_cnt", inflight_count_o, 1);
    end
    feedback_ready_i = 1;
    #1 chk("bp_cpl_ready1", cpl_ready_o, 1);
    step();
    cpl_valid_i = 0;
    chk("bp_second_a", feedback_her_addr_o, 32'h1c20_0600);
    chk("bp_second_id", feedback_msgid_o, 32'h3FF);
    step();
    chk("bp_drained", feedback_valid_o, 0);

    // out-of-order completion, including a zero-length packet
    alloc(32'h1c30_0000, 0, 1);
    alloc(32'h1c30_0600, 64, 2);
    alloc(32'h1c30_0c00, 9000, 3);
    cpl_fb("ooo_c", 32'h1c30_0c00, 9000, 3);
    cpl_fb("ooo_a", 32'h1c30_0000, 0, 1);
    cpl_fb("ooo_b", 32'h1c30_0600, 64, 2);

    // random traffic, checked by the model every cycle
    for (int k = 0; k < 8; k++) pool[k] = 32'h1c40_0000 + k * 32'h40;
    for (int n = 0; n < 1500; n++) begin
      rst              = ($urandom_range(0, 299) == 0);
      wr_done_valid_i  = $urandom_range(0, 1);
      wr_done_addr_i   = pool[$urandom_range(0, 7)];
      wr_done_len_i    = ($urandom_range(0, 7) == 0) ? 20'd0 : 20'($urandom_range(1, 9000));
      wr_done_tag_i    = $urandom;
      cpl_valid_i      = ($urandom_range(0, 2) == 0);
      cpl_addr_i       = ($urandom_range(0, 7) == 0) ? 32'hdead_beef : pool[$urandom_range(0, 7)];
      her_ready_i      = ($urandom_range(0, 3) != 0);
      feedback_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0; wr_done_valid_i = 0; cpl_valid_i = 0; her_ready_i = 1; feedback_ready_i = 1;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
